// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : async_fifo_pkg
// Purpose : Definitions shared by the write-side full generator and the
//           read-side empty generator of the async FIFO. Holds the default
//           address width and the Gray/binary conversion helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

   // Default RAM address width. The FIFO depth is 2**ADDRESS_SIZE.
   localparam int ADDRESS_SIZE = 4;

   // Gray-to-binary conversion on a 32-bit container. Bit i of the result is
   // the XOR of Gray bits i and above. Callers zero-extend narrower pointers,
   // which leaves the low bits of the result unaffected.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   // Binary-to-Gray conversion on a 32-bit container.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/write_pointer_full_generate_gray_to_binary.sv
`default_nettype none
// ============================================================================
// Module  : gray_to_binary
// Purpose : Combinational conversion of a Gray-coded pointer to binary.
// Ports   : gray - Gray-coded input,  width bits
//           bin  - binary equivalent,  width bits
// Revision: 1.0 - initial release
// ============================================================================
module gray_to_binary
   import async_fifo_pkg::*;
#(
   parameter int width = ADDRESS_SIZE + 1
) (
   input  logic [width-1:0] gray,
   output logic [width-1:0] bin
);

   assign bin = width'(gray2bin(32'(gray)));

endmodule : gray_to_binary
`default_nettype wire

// File: rtl/write_pointer_full_generate.sv
`default_nettype none
// ============================================================================
// Module  : write_pointer_full_generate
// Purpose : Write-domain pointer and full-flag generator for the async FIFO.
//           Keeps the binary/Gray write pointer, drives the RAM write address
//           and write enable, and compares against the synchronized read
//           pointer to produce full, almost-full, fill level and a sticky
//           overflow flag.
// Ports   : write_clk                  - write-domain clock
//           write_reset                - synchronous active-high reset
//           write_inc                  - producer write request
//           synchronized_read_pointer2 - read Gray pointer, 2-flop synced
//           write_accept               - RAM write enable (combinational)
//           write_address              - RAM write address
//           write_gray_pointer         - registered Gray write pointer
//           write_full                 - registered full flag
//           write_almost_full          - registered level >= threshold
//           write_level                - registered fill level
//           write_overflow             - sticky write-while-full flag
// Revision: 1.0 - initial release
// ============================================================================
module write_pointer_full_generate
   import async_fifo_pkg::*;
#(
   parameter int address_size          = ADDRESS_SIZE,
   parameter int almost_full_threshold = (2 ** address_size) - 2
) (
   input  logic                    write_clk,
   input  logic                    write_reset,
   input  logic                    write_inc,
   input  logic [address_size:0]   synchronized_read_pointer2,
   output logic                    write_accept,
   output logic [address_size-1:0] write_address,
   output logic [address_size:0]   write_gray_pointer,
   output logic                    write_full,
   output logic                    write_almost_full,
   output logic [address_size:0]   write_level,
   output logic                    write_overflow
);

   localparam int AS = address_size;
   localparam logic [AS:0] AF_THR = (AS + 1)'(almost_full_threshold);

   logic [AS:0] wbin_q, wbin_d;
   logic [AS:0] gray_q, gray_d;
   logic [AS:0] level_q, level_d;
   logic        full_q, full_d;
   logic        afull_q, afull_d;
   logic        ovf_q, ovf_d;
   logic [AS:0] rbin;
   logic [AS:0] rptr_wrapped;

   gray_to_binary #(
      .width (AS + 1)
   ) u_rptr_g2b (
      .gray (synchronized_read_pointer2),
      .bin  (rbin)
   );

   // A write is taken only when the registered full flag is clear.
   assign write_accept = write_inc & ~full_q;

   // The read pointer one lap behind the write pointer, in Gray code: the
   // two MSBs invert while the remaining bits match.
   assign rptr_wrapped = {~synchronized_read_pointer2[AS:AS-1],
                          synchronized_read_pointer2[AS-2:0]};

   always_comb begin
      wbin_d  = wbin_q + {{AS{1'b0}}, write_accept};
      gray_d  = (AS + 1)'(bin2gray(32'(wbin_d)));
      full_d  = (gray_d == rptr_wrapped);
      // Modulo subtraction across the extra wrap bit gives 0..2**AS.
      level_d = wbin_d - rbin;
      afull_d = (level_d >= AF_THR);
      ovf_d   = ovf_q | (write_inc & full_q);
   end

   always_ff @(posedge write_clk) begin
      if (write_reset) begin
         wbin_q  <= '0;
         gray_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         gray_q  <= gray_d;
         level_q <= level_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign write_address      = wbin_q[AS-1:0];
   assign write_gray_pointer = gray_q;
   assign write_full         = full_q;
   assign write_almost_full  = afull_q;
   assign write_level        = level_q;
   assign write_overflow     = ovf_q;

endmodule : write_pointer_full_generate
`default_nettype wire

// File: tb/tb_write_pointer_full_generate.sv
`default_nettype none
// ============================================================================
// Module  : tb_write_pointer_full_generate
// Purpose : Directed self-checking bench for write_pointer_full_generate with
//           address_size = 4. Expected outputs come from a small reference
//           model, are queued when a step is driven and compared after the
//           clock edge that produces them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_write_pointer_full_generate;

   localparam int AS = 4;

   typedef struct {
      logic [AS-1:0] addr;
      logic [AS:0]   gray;
      logic          full;
      logic          afull;
      logic [AS:0]   level;
      logic          ovf;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          inc;
   logic [AS:0]   rptr;
   logic          accept;
   logic [AS-1:0] addr;
   logic [AS:0]   gray;
   logic          full;
   logic          afull;
   logic [AS:0]   level;
   logic          ovf;

   int n_vec;
   int n_err;
   exp_t sb[$];

   // reference model state
   logic [AS:0] m_wbin;
   logic        m_full;
   logic        m_ovf;

   write_pointer_full_generate #(
      .address_size          (AS),
      .almost_full_threshold (14)
   ) dut (
      .write_clk                  (clk),
      .write_reset                (rst),
      .write_inc                  (inc),
      .synchronized_read_pointer2 (rptr),
      .write_accept               (accept),
      .write_address              (addr),
      .write_gray_pointer         (gray),
      .write_full                 (full),
      .write_almost_full          (afull),
      .write_level                (level),
      .write_overflow             (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AS:0] to_gray(input logic [AS:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AS:0] from_gray(input logic [AS:0] g);
      logic [AS:0] b;
      b[AS] = g[AS];
      for (int i = AS - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, predict the outputs after the edge, then compare.
   task automatic step(input logic r, input logic i, input logic [AS:0] rp);
      exp_t e;
      exp_t got;
      logic a;
      logic [AS:0] nb;
      rst  = r;
      inc  = i;
      rptr = rp;
      #1;
      a = i & ~m_full;
      chk("accept", 32'(accept), 32'(a));
      if (r) begin
         m_wbin = '0;
         m_full = 1'b0;
         m_ovf  = 1'b0;
         e.addr = '0; e.gray = '0; e.full = 1'b0; e.afull = 1'b0;
         e.level = '0; e.ovf = 1'b0;
      end else begin
         nb      = m_wbin + {{AS{1'b0}}, a};
         e.level = nb - from_gray(rp);
         e.full  = (e.level == 5'd16);
         e.afull = (e.level >= 5'd14);
         e.ovf   = m_ovf | (i & m_full);
         e.gray  = to_gray(nb);
         e.addr  = nb[AS-1:0];
         m_wbin  = nb;
         m_full  = e.full;
         m_ovf   = e.ovf;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("addr",  32'(addr),  32'(got.addr));
      chk("gray",  32'(gray),  32'(got.gray));
      chk("full",  32'(full),  32'(got.full));
      chk("afull", 32'(afull), 32'(got.afull));
      chk("level", 32'(level), 32'(got.level));
      chk("ovf",   32'(ovf),   32'(got.ovf));
   endtask

   initial begin
      logic [AS:0] prev;
      n_vec  = 0;
      n_err  = 0;
      m_wbin = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      rst    = 1'b1;
      inc    = 1'b1;
      rptr   = '0;
      @(posedge clk);
      #1;

      // reset held two cycles with write requests present
      step(1'b1, 1'b1, 5'b00000);
      step(1'b1, 1'b1, 5'b00000);
      step(1'b0, 1'b0, 5'b00000);
      chk("rst_gray", 32'(gray), 32'h0);

      // fill: 16 writes against an empty read side
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, 5'b00000);
         if (k == 0) chk("gray_first", 32'(gray), 32'b00001);
         if (k == 1) chk("gray_second", 32'(gray), 32'b00011);
         if (k == 12) chk("afull_13", 32'(afull), 32'h0);
         if (k == 13) chk("afull_14", 32'(afull), 32'h1);
         if (k == 14) chk("full_15", 32'(full), 32'h0);
      end
      chk("fill_gray", 32'(gray), 32'b11000);
      chk("fill_full", 32'(full), 32'h1);
      chk("fill_level", 32'(level), 32'd16);

      // overflow attempts while full, then release the request
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 5'b00000);
      chk("ovf_gray_held", 32'(gray), 32'b11000);
      chk("ovf_set", 32'(ovf), 32'h1);
      step(1'b0, 1'b0, 5'b00000);
      chk("ovf_sticky", 32'(ovf), 32'h1);

      // one read observed: full releases, one more write refills
      step(1'b0, 1'b0, 5'b00001);
      chk("drain_full", 32'(full), 32'h0);
      chk("drain_level", 32'(level), 32'd15);
      step(1'b0, 1'b1, 5'b00001);
      chk("refill_full", 32'(full), 32'h1);
      chk("refill_gray", 32'(gray), 32'b11001);

      // read pointer catches up, then 15 tracking writes reach pointer 0
      step(1'b0, 1'b0, to_gray(m_wbin));
      chk("caught_up_full", 32'(full), 32'h0);
      for (int k = 0; k < 15; k++) step(1'b0, 1'b1, to_gray(m_wbin));
      chk("at_zero", 32'(gray), 32'h0);

      // full lap of 32 writes with the read side tracking
      for (int k = 0; k < 32; k++) begin
         prev = gray;
         step(1'b0, 1'b1, to_gray(m_wbin));
         chk("one_bit_step", 32'($countones(prev ^ gray)), 32'd1);
         chk("wrap_no_full", 32'(full), 32'h0);
      end
      chk("wrap_gray", 32'(gray), 32'h0);
      chk("ovf_kept", 32'(ovf), 32'h1);

      // five writes, then a reset pulse with a write request present
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 5'b00000);
      chk("mid_level", 32'(level), 32'd5);
      step(1'b1, 1'b1, 5'b00000);
      chk("mid_rst_ovf", 32'(ovf), 32'h0);
      chk("mid_rst_gray", 32'(gray), 32'h0);
      step(1'b0, 1'b0, 5'b00000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_write_pointer_full_generate
`default_nettype wire
